keypad_scanner: RTL
===================

# keypad_scanner

Scans a 4x4 membrane keypad by driving one active-low column at a time and sampling the active-low rows. Debounces the scanned matrix and emits a one-cycle key event per press. Shifts accepted digits into a four-digit entry register whose BCD3..BCD0 outputs connect directly to the seven-segment display driver's digit inputs. This is the input-side counterpart to the multiplexed display: the display scans outputs, this block scans inputs.

## Interface
- SCAN_DIV, 131072: clock cycles each column stays driven; must be ≥ 4.
- DEBOUNCE, 4: consecutive identical full scans needed to accept a press or a release; must be ≥ 1.
- Clk  in  1  system clock, 100 MHz.
- nReset  in  1  one clock; reset is asynchronous and active-low.
- Rows  in  4  keypad rows, active-low, externally pulled up, asynchronous to Clk.
- Columns  out  4  column drive, exactly one bit low; reset 4'hE.
- KeyCode  out  4  code of the last accepted key; reset 4'h0.
- KeyValid  out  1  one-cycle pulse per accepted press; reset 0.
- BCD3, BCD2, BCD1, BCD0  out  4 each  entry register, BCD3 is the most significant digit; reset 4'h0 each.

## Operation
- Rows pass through a 2-flop synchroniser before any use.
- Scan counter counts 0..SCAN_DIV-1. On its terminal count, the synchronised Rows are captured for the current column, and Columns then rotates left: E→D→B→7→E.
- Column c (Columns[c] low) is captured into snapshot bits [4c+3:4c]. A full scan is complete when column 3 is captured.
- Key map, row r / column c: r0 = 1 2 3 A; r1 = 4 5 6 B; r2 = 7 8 9 C; r3 = E 0 F D. The '*' position is E and the '#' position is F.
- A scan is "single" if exactly one key is down, "none" if no key is down, and "multi" otherwise.
- FSM, evaluated once per completed scan:
  - IDLE: on a single scan, latch the candidate key and go to DEBOUNCE with stable count = 1.
  - DEBOUNCE: if the scan shows the same single key, increment the count. When the count reaches DEBOUNCE, go to PRESSED, pulse KeyValid and load KeyCode. A different key, none, or multi returns to IDLE.
  - PRESSED: a none scan goes to RELEASE with count = 1. Any other scan stays in PRESSED.
  - RELEASE: a none scan increments the count; at DEBOUNCE go to IDLE. Any key down returns to PRESSED.
- Multi scans never produce an event. Holding a key produces no repeat events.
- Entry register update on a KeyValid cycle, with the macro undefined:
  - Key 0-9: shift left, BCD3←BCD2, BCD2←BCD1, BCD1←BCD0, BCD0←key. The old BCD3 is discarded.
  - Key A: clear all four digits to 0.
  - Key B: backspace, i.e. shift right with BCD3←0.
  - Keys C-F: no change to the register; KeyValid still pulses.

## Timing
- Full scan period is 4×SCAN_DIV cycles.
- A press is accepted at the end of the DEBOUNCE-th consecutive identical scan.
- KeyValid is high in the cycle after the FSM transitions to PRESSED. KeyCode is valid in that same cycle and holds until the next accepted key.
- BCD outputs change in the cycle after KeyValid.
- Input-to-capture adds 2 cycles of synchroniser latency.
- nReset low forces every register to its reset value immediately, including mid-scan and mid-debounce. Scanning restarts at column 0 with a zeroed counter on the first Clk edge after release.
- A press already held during reset release is accepted normally after DEBOUNCE scans.

## Configuration
- KEYPAD_HEX_EN defined: all 16 codes 0-F shift into the register as hex digits. A and B are not commands.
- KEYPAD_HEX_EN undefined: decimal entry with the A = clear, B = backspace behaviour above.
- KeyCode and KeyValid behave identically in both builds.

## Structure
- Shared package keypad_pkg holds:
  - the FSM state enum (IDLE, DEBOUNCE, PRESSED, RELEASE);
  - the 16-entry row/column→code map constant;
  - the command codes KEY_CLEAR = 4'hA and KEY_BACK = 4'hB.
- Sub-module keypad_entry holds the four-digit register and its command decode, driven by KeyCode and KeyValid.

## Test plan
Bench runs with SCAN_DIV = 4 and DEBOUNCE = 2.
- Reset: assert nReset low mid-scan → Columns = E, KeyValid = 0, KeyCode = 0, all BCD = 0 within the same cycle, and they stay so until release.
- Press: hold key '5' (r1/c1) for 3 scans → exactly one KeyValid pulse with KeyCode = 5 and BCD0 = 5, then no further pulses while held.
- Entry sequence: press 1, 2, 3, 4, 7 with full releases between → BCD3..0 = 2,3,4,7. Then press B → 0,2,3,4. Then press A → 0,0,0,0.
- Bounce: key '8' toggles every column period for 2 scans, then holds steady → no pulse during toggling, one pulse with KeyCode = 8 after 2 stable scans.
- Multi-key: hold '1' and '9' together for 5 scans → no KeyValid. Then release '9' → pulse with KeyCode = 1 after 2 scans.
- KEYPAD_HEX_EN build: press 'C' then 'F' (the '#' position) → BCD1 = C and BCD0 = F; key A shifts in as a digit instead of clearing.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner: FSM states,
// scan-position-to-key map and entry-register command codes.
package keypad_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_DEBOUNCE,
      S_PRESSED,
      S_RELEASE
   } key_state_t;

   // Nibble at scan index 4*column+row holds that position's key code.
   localparam logic [63:0] KEY_MAP = 64'hDCBA_F963_0852_E741;

   localparam logic [3:0] KEY_CLEAR = 4'hA;
   localparam logic [3:0] KEY_BACK  = 4'hB;

   function automatic logic [3:0] key_code(input logic [3:0] idx);
      return KEY_MAP[{idx, 2'b00} +: 4];
   endfunction

endpackage

// File: rtl/keypad_entry.sv
// Four-digit entry register fed by accepted keys. Define KEYPAD_HEX_EN to shift
// in all sixteen codes as hex digits; otherwise decimal entry with A/B commands.
module keypad_entry
   import keypad_pkg::*;
(
   input  logic       Clk,
   input  logic       nReset,
   input  logic [3:0] KeyCode,
   input  logic       KeyValid,
   output logic [3:0] BCD3,
   output logic [3:0] BCD2,
   output logic [3:0] BCD1,
   output logic [3:0] BCD0
);

   always_ff @(posedge Clk or negedge nReset) begin
      if (!nReset) begin
         BCD3 <= '0;
         BCD2 <= '0;
         BCD1 <= '0;
         BCD0 <= '0;
      end else if (KeyValid) begin
`ifdef KEYPAD_HEX_EN
         BCD3 <= BCD2;
         BCD2 <= BCD1;
         BCD1 <= BCD0;
         BCD0 <= KeyCode;
`else
         if (KeyCode <= 4'd9) begin
            BCD3 <= BCD2;
            BCD2 <= BCD1;
            BCD1 <= BCD0;
            BCD0 <= KeyCode;
         end else if (KeyCode == KEY_CLEAR) begin
            BCD3 <= '0;
            BCD2 <= '0;
            BCD1 <= '0;
            BCD0 <= '0;
         end else if (KeyCode == KEY_BACK) begin
            BCD3 <= '0;
            BCD2 <= BCD3;
            BCD1 <= BCD2;
            BCD0 <= BCD1;
         end
`endif
      end
   end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad column scanner with scan-level debounce and digit entry register.
// Entry behaviour depends on KEYPAD_HEX_EN (see keypad_entry).
module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int unsigned SCAN_DIV = 131072,
   parameter int unsigned DEBOUNCE = 4
) (
   input  logic       Clk,
   input  logic       nReset,
   input  logic [3:0] Rows,
   output logic [3:0] Columns,
   output logic [3:0] KeyCode,
   output logic       KeyValid,
   output logic [3:0] BCD3,
   output logic [3:0] BCD2,
   output logic [3:0] BCD1,
   output logic [3:0] BCD0
);

   localparam int unsigned SW = $clog2(SCAN_DIV);
   localparam int unsigned CW = $clog2(DEBOUNCE + 1);

   logic [3:0]    rows_s1;
   logic [3:0]    rows_s2;
   logic [SW-1:0] scan_cnt;
   logic [1:0]    col;
   logic [15:0]   snap;
   logic          scan_done;
   logic          tc;
   key_state_t    state;
   logic [3:0]    cand;
   logic [CW-1:0] stable;
   logic [4:0]    ones;
   logic [3:0]    hit;
   logic          single;
   logic          none;

   assign tc = (scan_cnt == SW'(SCAN_DIV - 1));

   always_ff @(posedge Clk or negedge nReset) begin
      if (!nReset) begin
         rows_s1   <= '1;
         rows_s2   <= '1;
         scan_cnt  <= '0;
         col       <= '0;
         Columns   <= 4'hE;
         snap      <= '0;
         scan_done <= 1'b0;
      end else begin
         rows_s1   <= Rows;
         rows_s2   <= rows_s1;
         scan_done <= tc && (col == 2'd3);
         if (tc) begin
            scan_cnt                 <= '0;
            snap[{col, 2'b00} +: 4] <= ~rows_s2;
            col                      <= col + 2'd1;
            Columns                  <= {Columns[2:0], Columns[3]};
         end else begin
            scan_cnt <= scan_cnt + SW'(1);
         end
      end
   end

   always_comb begin
      ones = '0;
      hit  = '0;
      for (int unsigned i = 0; i < 16; i++) begin
         if (snap[i]) begin
            ones = ones + 5'd1;
            hit  = 4'(i);
         end
      end
      single = (ones == 5'd1);
      none   = (ones == 5'd0);
   end

   // Evaluated one cycle after column 3 is captured, so snap holds a whole scan.
   always_ff @(posedge Clk or negedge nReset) begin
      if (!nReset) begin
         state    <= S_IDLE;
         cand     <= '0;
         stable   <= '0;
         KeyCode  <= '0;
         KeyValid <= 1'b0;
      end else begin
         KeyValid <= 1'b0;
         if (scan_done) begin
            case (state)
               S_IDLE: begin
                  if (single) begin
                     cand   <= hit;
                     stable <= CW'(1);
                     if (DEBOUNCE == 1) begin
                        state    <= S_PRESSED;
                        KeyValid <= 1'b1;
                        KeyCode  <= key_code(hit);
                     end else begin
                        state <= S_DEBOUNCE;
                     end
                  end
               end
               S_DEBOUNCE: begin
                  if (single && hit == cand) begin
                     if (stable + CW'(1) == CW'(DEBOUNCE)) begin
                        state    <= S_PRESSED;
                        KeyValid <= 1'b1;
                        KeyCode  <= key_code(cand);
                     end else begin
                        stable <= stable + CW'(1);
                     end
                  end else begin
                     state <= S_IDLE;
                  end
               end
               S_PRESSED: begin
                  if (none) begin
                     stable <= CW'(1);
                     state  <= (DEBOUNCE == 1) ? S_IDLE : S_RELEASE;
                  end
               end
               S_RELEASE: begin
                  if (none) begin
                     if (stable + CW'(1) == CW'(DEBOUNCE)) begin
                        state <= S_IDLE;
                     end else begin
                        stable <= stable + CW'(1);
                     end
                  end else begin
                     state <= S_PRESSED;
                  end
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

   keypad_entry u_entry (
      .Clk      (Clk),
      .nReset   (nReset),
      .KeyCode  (KeyCode),
      .KeyValid (KeyValid),
      .BCD3     (BCD3),
      .BCD2     (BCD2),
      .BCD1     (BCD1),
      .BCD0     (BCD0)
   );

endmodule
